div_issue_scheduler: RTL and testbench

- Shares one iterative divider between NUM_RS reservation stations using round-robin arbitration.
- Latches the granted operation's operands, commands and tag, and sequences the divider's valid_in/valid_out handshake.
- Short-circuits divide-by-zero and guards against a hung divider with a timeout.
- Presents one result to the execution decision unit and holds it until canGo_i.

---
 rtl/div_issue_scheduler.sv | 133 +++++++++++++
 tb/tb_div_issue_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_scheduler.sv
// div_issue_scheduler: round-robin issue of NUM_RS reservation stations onto one shared iterative divider
module div_issue_scheduler #(
  parameter int ROBsize     = 32,
  parameter int ROBsizeLog  = $clog2(ROBsize+1),
  parameter int NUM_RS      = 2,
  parameter int DIV_TIMEOUT = 128
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [NUM_RS-1:0]            readyRS_i,
  input  logic [64*NUM_RS-1:0]         rsVal1_i,
  input  logic [64*NUM_RS-1:0]         rsVal2_i,
  input  logic [10*NUM_RS-1:0]         rsCommands_i,
  input  logic [ROBsizeLog*NUM_RS-1:0] rsTag_i,
  output logic [NUM_RS-1:0]            stallRS_o,
  output logic                         div_valid_in_o,
  output logic [63:0]                  div_dividend_o,
  output logic [63:0]                  div_divisor_o,
  input  logic                         div_valid_out_i,
  input  logic [63:0]                  div_quotient_i,
  input  logic                         canGo_i,
  output logic                         valid_o,
  output logic [63:0]                  executeVal_o,
  output logic [9:0]                   executeCommands_o,
  output logic [ROBsizeLog-1:0]        executeTag_o,
  output logic [3:0]                   executeFlags_o,
  output logic                         busy_o
);
  localparam int PW = $clog2(NUM_RS);
  localparam int CW = $clog2(DIV_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d, gnt, idx;
  logic                   any_req;
  logic [63:0]            val1_q, val1_d, val2_q, val2_d, res_q, res_d;
  logic [9:0]             cmd_q, cmd_d;
  logic [ROBsizeLog-1:0]  tag_q, tag_d;
  logic [1:0]             flg_q, flg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [63:0]            a_g, b_g;
  // Scan downward so the station closest after ptr_q is the last (winning) assignment
  always_comb begin
    gnt = ptr_q;
    idx = '0;
    any_req = 1'b0;
    for (int i = NUM_RS; i >= 1; i--) begin
      idx = PW'((int'(ptr_q) + i) % NUM_RS);
      if (readyRS_i[idx]) begin
        gnt = idx;
        any_req = 1'b1;
      end
    end
  end
  assign a_g = rsVal1_i[int'(gnt)*64 +: 64];
  assign b_g = rsVal2_i[int'(gnt)*64 +: 64];
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    val1_d = val1_q;
    val2_d = val2_q;
    cmd_d = cmd_q;
    tag_d = tag_q;
    res_d = res_q;
    flg_d = flg_q;
    cnt_d = cnt_q;
    stallRS_o = '1;
    case (state_q)
      IDLE: if (any_req) begin
        stallRS_o[gnt] = 1'b0;
        ptr_d = gnt;
        val1_d = a_g;
        val2_d = b_g;
        cmd_d = rsCommands_i[int'(gnt)*10 +: 10];
        tag_d = rsTag_i[int'(gnt)*ROBsizeLog +: ROBsizeLog];
        if (b_g == '0) begin
          res_d = '1;
          flg_d = 2'b01;
          state_d = DONE;
        end else state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_valid_out_i) begin
          res_d = div_quotient_i;
          flg_d = 2'b00;
          state_d = DONE;
        end else if (cnt_q == CW'(DIV_TIMEOUT-1)) begin
          res_d = '0;
          flg_d = 2'b10;
          state_d = DONE;
        end
      end
      DONE: state_d = canGo_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q <= PW'(NUM_RS-1);
      val1_q <= '0;
      val2_q <= '0;
      cmd_q <= '0;
      tag_q <= '0;
      res_q <= '0;
      flg_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
      cmd_q <= cmd_d;
      tag_q <= tag_d;
      res_q <= res_d;
      flg_q <= flg_d;
      cnt_q <= cnt_d;
    end
  end
  assign div_valid_in_o    = state_q == ISSUE;
  assign div_dividend_o    = val1_q;
  assign div_divisor_o     = val2_q;
  assign valid_o           = state_q == DONE;
  assign busy_o            = state_q != IDLE;
  assign executeVal_o      = res_q;
  assign executeCommands_o = cmd_q;
  assign executeTag_o      = tag_q;
  assign executeFlags_o    = {2'b00, flg_q};
endmodule

// File: tb/tb_div_issue_scheduler.sv
// tb_div_issue_scheduler: per-cycle vector table plus hand sequences for timeout, backpressure and reset
module tb_div_issue_scheduler;
  localparam int TW = 6;
  logic         clk = 0, rst_n = 0;
  logic [1:0]   rdy = 0;
  logic [127:0] v1 = 0, v2 = 0;
  logic [19:0]  cmds = {10'd20, 10'd10};
  logic [11:0]  tags = {6'd7, 6'd3};
  logic         dvo = 0, go = 0;
  logic [63:0]  quo = 0;
  logic [1:0]   stall;
  logic         vin, valid, busy;
  logic [63:0]  dd, ds, val;
  logic [9:0]   cmd;
  logic [TW-1:0] tag;
  logic [3:0]   flg;
  int checks = 0, failures = 0;

  div_issue_scheduler #(.ROBsize(32), .NUM_RS(2), .DIV_TIMEOUT(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .readyRS_i(rdy), .rsVal1_i(v1), .rsVal2_i(v2),
    .rsCommands_i(cmds), .rsTag_i(tags), .stallRS_o(stall), .div_valid_in_o(vin),
    .div_dividend_o(dd), .div_divisor_o(ds), .div_valid_out_i(dvo), .div_quotient_i(quo),
    .canGo_i(go), .valid_o(valid), .executeVal_o(val), .executeCommands_o(cmd),
    .executeTag_o(tag), .executeFlags_o(flg), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ops;
    logic [1:0]  rdy;
    logic        go, dvo;
    logic [63:0] q;
    logic [1:0]  st;
    logic        vi;
    logic [63:0] edd, eds;
    logic        bz, vl;
    logic [63:0] ev;
    logic [3:0]  ef;
    logic [5:0]  et;
    logic [9:0]  ec;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int s);
    if (s == 0) begin
      v1 = {64'd100, 64'd15};
      v2 = {64'd0, 64'd3};
    end else begin
      v1 = {64'd21, 64'd20};
      v2 = {64'd7, 64'd4};
    end
  endtask

  initial begin
    // ops rdy go dvo q | stall vin dd ds busy valid val flags tag cmd
    vt.push_back('{0, 2'b01, 0, 0, 0,  2'b10, 0, 0, 0,   0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 2'b00, 0, 0, 0,  2'b11, 1, 15, 3,  1, 0, 0, 0, 0, 0});
    for (int k = 0; k < 4; k++)
      vt.push_back('{0, 2'b00, 0, 0, 0, 2'b11, 0, 0, 0,  1, 0, 0, 0, 0, 0});
    vt.push_back('{0, 2'b00, 0, 1, 5,  2'b11, 0, 0, 0,   1, 0, 0, 0, 0, 0});
    vt.push_back('{0, 2'b00, 0, 1, 99, 2'b11, 0, 0, 0,   1, 1, 5, 0, 3, 10});
    vt.push_back('{0, 2'b00, 1, 0, 0,  2'b11, 0, 0, 0,   1, 1, 5, 0, 3, 10});
    vt.push_back('{0, 2'b00, 0, 0, 0,  2'b11, 0, 0, 0,   0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 2'b10, 0, 0, 0,  2'b01, 0, 0, 0,   0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 2'b00, 1, 0, 0,  2'b11, 0, 0, 0,   1, 1, {64{1'b1}}, 4'b0001, 7, 20});
    vt.push_back('{0, 2'b00, 0, 1, 77, 2'b11, 0, 0, 0,   0, 0, 0, 0, 0, 0});
    for (int r = 0; r < 2; r++) begin
      vt.push_back('{1, 2'b11, 0, 0, 0, 2'b10, 0, 0, 0,  0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 2'b11, 0, 0, 0, 2'b11, 1, 20, 4, 1, 0, 0, 0, 0, 0});
      vt.push_back('{1, 2'b11, 0, 1, 5, 2'b11, 0, 0, 0,  1, 0, 0, 0, 0, 0});
      vt.push_back('{1, 2'b11, 1, 0, 0, 2'b11, 0, 0, 0,  1, 1, 5, 0, 3, 10});
      vt.push_back('{1, 2'b11, 0, 0, 0, 2'b01, 0, 0, 0,  0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 2'b11, 0, 0, 0, 2'b11, 1, 21, 7, 1, 0, 0, 0, 0, 0});
      vt.push_back('{1, 2'b11, 0, 1, 3, 2'b11, 0, 0, 0,  1, 0, 0, 0, 0, 0});
      vt.push_back('{1, 2'b11, 1, 0, 0, 2'b11, 0, 0, 0,  1, 1, 3, 0, 7, 20});
    end
    vt.push_back('{1, 2'b00, 0, 0, 0,  2'b11, 0, 0, 0,   0, 0, 0, 0, 0, 0});

    @(negedge clk);
    #1;
    chk("rst stall", stall, 2'b11);
    chk("rst vin", vin, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    chk("rst val", val, 0);
    chk("rst flags", flg, 0);
    chk("rst tag", tag, 0);
    chk("rst dividend", dd, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vt[i]) begin
      @(negedge clk);
      set_ops(vt[i].ops);
      rdy = vt[i].rdy;
      go = vt[i].go;
      dvo = vt[i].dvo;
      quo = vt[i].q;
      #1;
      chk($sformatf("v%0d stall", i), stall, vt[i].st);
      chk($sformatf("v%0d vin", i), vin, vt[i].vi);
      chk($sformatf("v%0d busy", i), busy, vt[i].bz);
      chk($sformatf("v%0d valid", i), valid, vt[i].vl);
      if (vt[i].vi) begin
        chk($sformatf("v%0d dividend", i), dd, vt[i].edd);
        chk($sformatf("v%0d divisor", i), ds, vt[i].eds);
      end
      if (vt[i].vl) begin
        chk($sformatf("v%0d val", i), val, vt[i].ev);
        chk($sformatf("v%0d flags", i), flg, vt[i].ef);
        chk($sformatf("v%0d tag", i), tag, vt[i].et);
        chk($sformatf("v%0d cmd", i), cmd, vt[i].ec);
      end
    end

    // timeout: divider never answers, DIV_TIMEOUT = 8
    @(negedge clk);
    set_ops(0);
    rdy = 2'b01;
    go = 0;
    dvo = 0;
    #1;
    chk("to grant", stall, 2'b10);
    @(negedge clk);
    rdy = 0;
    #1;
    chk("to issue", vin, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to wait%0d valid", k), valid, 0);
      chk($sformatf("to wait%0d busy", k), busy, 1);
    end
    @(negedge clk);
    #1;
    chk("to valid", valid, 1);
    chk("to val", val, 0);
    chk("to flags", flg, 4'b0010);
    chk("to tag", tag, 3);

    // backpressure: station 1 waits while the result is held
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_ops(1);
      rdy = 2'b10;
      go = 0;
      #1;
      chk($sformatf("bp%0d valid", k), valid, 1);
      chk($sformatf("bp%0d val", k), val, 0);
      chk($sformatf("bp%0d flags", k), flg, 4'b0010);
      chk($sformatf("bp%0d tag", k), tag, 3);
      chk($sformatf("bp%0d cmd", k), cmd, 10);
      chk($sformatf("bp%0d stall", k), stall, 2'b11);
    end
    @(negedge clk);
    go = 1;
    #1;
    chk("bp handshake valid", valid, 1);
    chk("bp handshake stall", stall, 2'b11);
    @(negedge clk);
    go = 0;
    #1;
    chk("bp regrant stall", stall, 2'b01);
    chk("bp regrant valid", valid, 0);
    @(negedge clk);
    rdy = 0;
    #1;
    chk("bp issue vin", vin, 1);
    chk("bp issue dividend", dd, 21);
    chk("bp issue divisor", ds, 7);

    // reset asserted while in WAIT
    @(negedge clk);
    #1;
    chk("mr wait busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mr valid", valid, 0);
    chk("mr busy", busy, 0);
    chk("mr stall", stall, 2'b11);
    chk("mr dividend", dd, 0);
    chk("mr flags", flg, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dvo = 1;
    quo = 77;
    #1;
    chk("mr late busy", busy, 0);
    @(negedge clk);
    dvo = 0;
    #1;
    chk("mr late valid", valid, 0);
    chk("mr late busy2", busy, 0);
    chk("mr late val", val, 0);
    @(negedge clk);
    rdy = 2'b11;
    #1;
    chk("mr ptr reset stall", stall, 2'b10);
    @(negedge clk);
    rdy = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
